// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank write-back path.
package regbank_pkg;

  typedef logic [3:0]  RegAddr_t;
  typedef logic [31:0] Word_t;

  localparam int       NUM_REGS = 16;
  localparam RegAddr_t REG_ZERO = 4'd0;
  localparam RegAddr_t REG_IP   = 4'd15;

  typedef struct packed {
    RegAddr_t Address;
    Word_t    Data;
  } WbEntry_t;

  typedef enum logic {
    GRANT_ALU  = 1'b0,
    GRANT_LOAD = 1'b1
  } Grant_t;

  // r0 is hardwired zero, so it never contributes a pending bit.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input RegAddr_t addr);
    logic [NUM_REGS-1:0] vec;
    vec = '0;
    if (addr != REG_ZERO) vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small skid FIFO for one write-back producer; exposes every slot so the
// owner can build a pending-register mask.
module wb_fifo
  import regbank_pkg::*;
#(
  parameter int FifoDepth = 2
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       push,
  input  WbEntry_t                   push_entry,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output WbEntry_t                   head,
  output logic [FifoDepth-1:0]       entry_valid,
  output WbEntry_t [FifoDepth-1:0]   entries
);

  localparam int IdxW = $clog2(FifoDepth);
  localparam int PtrW = IdxW + 1;

  WbEntry_t [FifoDepth-1:0] mem;
  logic [PtrW-1:0]          wr_ptr;
  logic [PtrW-1:0]          rd_ptr;
  logic [PtrW-1:0]          count;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign full    = (wr_ptr[IdxW] != rd_ptr[IdxW]) &&
                   (wr_ptr[IdxW-1:0] == rd_ptr[IdxW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[IdxW-1:0]];
  assign entries = mem;

  for (genvar i = 0; i < FifoDepth; i++) begin : g_valid
    assign entry_valid[i] = ({1'b0, IdxW'(i) - rd_ptr[IdxW-1:0]} < count);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[IdxW-1:0]] <= push_entry;
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_writeback_arbiter.sv
// Round-robin sharing of the register bank write port between the ALU and
// the load unit, with a registered write stage and a pending-register mask.
module regbank_writeback_arbiter
  import regbank_pkg::*;
#(
  parameter int FifoDepth = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        AluValid,
  output logic        AluReady,
  input  logic [3:0]  AluAddress,
  input  logic [31:0] AluData,
  input  logic        LoadValid,
  output logic        LoadReady,
  input  logic [3:0]  LoadAddress,
  input  logic [31:0] LoadData,
  output logic        TargetWriteEnable,
  output logic [3:0]  TargetAddress,
  output logic [31:0] TargetIn,
  output logic        IpWritten,
  output logic [15:0] PendingMask
);

  logic                     alu_full, alu_empty, load_full, load_empty;
  logic                     alu_push, load_push;
  logic                     grant_alu, grant_load;
  WbEntry_t                 alu_head, load_head, granted;
  logic [FifoDepth-1:0]     alu_valid_vec, load_valid_vec;
  WbEntry_t [FifoDepth-1:0] alu_entries, load_entries;
  Grant_t                   last_grant;
  logic [NUM_REGS-1:0]      mask;

  assign AluReady  = !alu_full;
  assign LoadReady = !load_full;
  assign alu_push  = AluValid && AluReady;
  assign load_push = LoadValid && LoadReady;

  wb_fifo #(.FifoDepth(FifoDepth)) u_alu_fifo (
    .Clock       (Clock),
    .Reset       (Reset),
    .push        (alu_push),
    .push_entry  ('{Address: AluAddress, Data: AluData}),
    .pop         (grant_alu),
    .full        (alu_full),
    .empty       (alu_empty),
    .head        (alu_head),
    .entry_valid (alu_valid_vec),
    .entries     (alu_entries)
  );

  wb_fifo #(.FifoDepth(FifoDepth)) u_load_fifo (
    .Clock       (Clock),
    .Reset       (Reset),
    .push        (load_push),
    .push_entry  ('{Address: LoadAddress, Data: LoadData}),
    .pop         (grant_load),
    .full        (load_full),
    .empty       (load_empty),
    .head        (load_head),
    .entry_valid (load_valid_vec),
    .entries     (load_entries)
  );

  // On a tie the requester that did not win last time gets the port.
  assign grant_alu  = !alu_empty && (load_empty || last_grant == GRANT_LOAD);
  assign grant_load = !load_empty && !grant_alu;
  assign granted    = grant_alu ? alu_head : load_head;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      TargetWriteEnable <= 1'b0;
      TargetAddress     <= '0;
      TargetIn          <= '0;
      last_grant        <= GRANT_LOAD;
    end else if (grant_alu || grant_load) begin
      TargetWriteEnable <= (granted.Address != REG_ZERO);
      TargetAddress     <= granted.Address;
      TargetIn          <= granted.Data;
      last_grant        <= grant_alu ? GRANT_ALU : GRANT_LOAD;
    end else begin
      TargetWriteEnable <= 1'b0;
    end
  end

  assign IpWritten = TargetWriteEnable && (TargetAddress == REG_IP);

  always_comb begin
    mask = '0;
    for (int i = 0; i < FifoDepth; i++) begin
      if (alu_valid_vec[i])  mask = mask | reg_onehot(alu_entries[i].Address);
      if (load_valid_vec[i]) mask = mask | reg_onehot(load_entries[i].Address);
    end
    if (TargetWriteEnable) mask = mask | reg_onehot(TargetAddress);
  end

  assign PendingMask = mask;

endmodule
